// File: rtl/instr_issue_sequencer.sv
// Issues a buffered instruction program over the load/s/w handshake to the instruction controller.
// Optional build macro SEQ_TIMEOUT_EN adds a handshake watchdog that sets a sticky error flag.
module instr_issue_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          w,
    output logic [15:0]   instr,
    output logic          load,
    output logic          s,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   len;
    logic          last;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          expired;

    assign expired = (cnt == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
`endif

    assign last = ({1'b0, pc} == (len - (AW + 1)'(1)));

    // Program buffer: writable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM; load, s and done are one-cycle pulses set on state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            instr <= '0;
            load  <= 1'b0;
            s     <= 1'b0;
            pc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            len   <= '0;
`ifdef SEQ_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            load <= 1'b0;
            s    <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        busy  <= 1'b1;
                        if (prog_len != '0) begin
                            len   <= prog_len;
                            pc    <= '0;
                            state <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                end
                S_FETCH: begin
                    instr <= mem[pc];
                    load  <= 1'b1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Only strobe s once the controller reports it is waiting.
                    if (w) begin
                        s     <= 1'b1;
                        state <= S_WAIT_ACK;
`ifdef SEQ_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                S_WAIT_ACK: begin
                    if (!w) begin
                        state <= S_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (expired) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= cnt + CW'(1);
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (w) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            pc    <= pc + AW'(1);
                            state <= S_FETCH;
                        end
`ifdef SEQ_TIMEOUT_EN
                    end else if (expired) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= cnt + CW'(1);
`endif
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Scoreboard bench for instr_issue_sequencer with a behavioural controller driving w.
module tb_instr_issue_sequencer;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          w;
    logic [15:0]   instr;
    logic          load;
    logic          s;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          error;

    int compared = 0;
    int mismatched = 0;
    int load_cnt = 0;
    int s_cnt = 0;
    int done_cnt = 0;
    logic pending = 1'b0;
    logic [1:0] w_hist = 2'b11;
    logic [1:0] done_hist = 2'b00;
    logic [15:0] exp_q[$];

    // Controller model: lowers w the cycle after sampling s, stays busy for lat+1 cycles.
    logic w_model = 1'b1;
    logic force_low = 1'b0;
    logic stuck = 1'b0;
    int   busy_left = 0;
    int   lat = 2;

    instr_issue_sequencer #(.DEPTH(16), .AW(AW), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .w(w),
        .instr(instr), .load(load), .s(s), .pc(pc), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    assign w = force_low ? 1'b0 : w_model;

    always @(posedge clk) begin
        if (reset) begin
            w_model   <= 1'b1;
            busy_left <= 0;
        end else if (w_model && s && !stuck) begin
            w_model   <= 1'b0;
            busy_left <= lat;
        end else if (!w_model) begin
            if (busy_left == 0) w_model <= 1'b1;
            else busy_left <= busy_left - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each load and checks pulse ordering.
    always @(negedge clk) begin
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (load) begin
                load_cnt++;
                if (exp_q.size() == 0) begin
                    check("load_unexpected", 32'(load), 32'd0);
                end else begin
                    check("load_instr", 32'(instr), 32'(exp_q.pop_front()));
                end
                check("load_before_prev_s", 32'(pending), 32'd0);
                check("pulse_overlap", 32'({load, s, done}), 32'b100);
                pending = 1'b1;
            end
            if (s) begin
                s_cnt++;
                check("s_after_load", 32'(pending), 32'd1);
                check("s_while_w_high", 32'(w), 32'd1);
                pending = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_hist = w_hist;
            end
        end
        w_hist = {w_hist[0], w};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        prog_addr = AW'(a);
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic run_start(input int n);
        prog_len = (AW + 1)'(n);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_s(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (s) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int l0, s0, d0;
        bit seen;

        // Reset with start held high: outputs stay cleared, start ignored.
        reset = 1'b1;
        start = 1'b1;
        prog_len = 5'd3;
        tick();
        tick();
        @(negedge clk);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Normal three-instruction program.
        wr(0, 16'hD007);
        wr(1, 16'hD102);
        wr(2, 16'hA248);
        exp_q.push_back(16'hD007);
        exp_q.push_back(16'hD102);
        exp_q.push_back(16'hA248);
        l0 = load_cnt; s0 = s_cnt; d0 = done_cnt;
        run_start(3);
        wait_done("normal_done_seen");
        @(negedge clk);
        check("normal_done_after_w_rise", 32'(done_hist), 32'b01);
        check("normal_done_width", 32'(done), 32'd0);
        check("normal_s_count", 32'(s_cnt - s0), 32'd3);
        check("normal_load_count", 32'(load_cnt - l0), 32'd3);
        check("normal_done_count", 32'(done_cnt - d0), 32'd1);
        check("normal_pc_end", 32'(pc), 32'd2);
        check("normal_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("idle_instr_hold", 32'(instr), 32'hA248);
        check("idle_pc_hold", 32'(pc), 32'd2);
        check("idle_busy", 32'(busy), 32'd0);

        // Empty program: done on the cycle after start, no load or s.
        l0 = load_cnt; s0 = s_cnt;
        run_start(0);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("empty_done_width", 32'(done), 32'd0);
        check("empty_busy_after", 32'(busy), 32'd0);
        check("empty_no_load", 32'(load_cnt - l0), 32'd0);
        check("empty_no_s", 32'(s_cnt - s0), 32'd0);

        // Backpressure: w held low while in ISSUE keeps s low.
        exp_q.push_back(16'hD007);
        run_start(1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (load) seen = 1'b1;
        end
        check("bp_load_seen", 32'(seen), 32'd1);
        force_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_s_low", 32'(s), 32'd0);
        end
        force_low = 1'b0;
        @(negedge clk);
        check("bp_s_on_w_high", 32'(s), 32'd1);
        wait_done("bp_done_seen");
        @(negedge clk);
        check("bp_pc_end", 32'(pc), 32'd0);

        // Reset during WAIT_DONE of the second instruction.
        exp_q.push_back(16'hD007);
        exp_q.push_back(16'hD102);
        d0 = done_cnt;
        run_start(3);
        wait_s("mid_s1");
        wait_s("mid_s2");
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!w) seen = 1'b1;
        end
        check("mid_w_low_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(16'hD007);
        exp_q.push_back(16'hD102);
        exp_q.push_back(16'hA248);
        s0 = s_cnt;
        tick();
        run_start(3);
        wait_done("restart_done_seen");
        @(negedge clk);
        check("restart_s_count", 32'(s_cnt - s0), 32'd3);
        check("restart_pc_end", 32'(pc), 32'd2);

`ifdef SEQ_TIMEOUT_EN
        // Controller never leaves wait: error exactly 32 cycles after s.
        stuck = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(16'hD007);
        run_start(1);
        wait_s("to_s_seen");
        repeat (31) @(negedge clk);
        check("to_error_early", 32'(error), 32'd0);
        check("to_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        check("to_error", 32'(error), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_done", 32'(done), 32'd0);
        @(negedge clk);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        check("to_error_sticky", 32'(error), 32'd1);
        stuck = 1'b0;
        exp_q.push_back(16'hD007);
        tick();
        run_start(1);
        @(negedge clk);
        check("to_error_cleared", 32'(error), 32'd0);
        wait_done("to_recover_done");
        @(negedge clk);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
